usr_serializer: RTL and testbench

USR_SERIALIZER -- requirements
Module: usr_serializer

---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_serializer_bit_timer.sv | 30 +++
 rtl/usr_serializer.sv | 133 +++++++++++++
 tb/tb_usr_serializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the serializer: shift-register mode codes and the
// frame state machine encoding.
package usr_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

endpackage

// File: rtl/usr_serializer_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while a frame runs and emits a
// one-cycle bit_tick on the last cycle of every serial bit period.
module bit_timer #(
   parameter int DIV = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(DIV + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   assign bit_tick = run && (cnt_q == LAST_CNT);

   // Free-running period counter, held at zero whenever no frame is running.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (!run || cnt_q == LAST_CNT) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/usr_serializer.sv
// Parallel-to-serial converter: start bit (0), WIDTH data bits in a
// selectable order, stop bit (1); each bit lasts DIV clock cycles.
module usr_serializer
   import usr_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] DATAIN,
   input  logic             msb_first,
   input  logic             abort,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

   state_t           state_q, state_n;
   logic [WIDTH-1:0] shreg_q, shreg_n;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_n;
   logic [1:0]       mode;
   logic             msb_q, msb_n;
   logic             armed_q;
   logic             accept;
   logic             done_n;
   logic             serial_n;
   logic             bit_tick;
   logic             timer_run;

   assign busy      = (state_q != IDLE);
   assign in_ready  = (state_q == IDLE) && armed_q;
   assign timer_run = busy && !abort;

   bit_timer #(.DIV(DIV)) u_bit_timer (
      .clock    (clock),
      .reset    (reset),
      .run      (timer_run),
      .bit_tick (bit_tick)
   );

   // Frame sequencing: picks the next state, the shift-register mode and the
   // data-bit count; an abort outside IDLE overrides everything.
   always_comb begin
      accept    = 1'b0;
      state_n   = state_q;
      mode      = MODE_HOLD;
      bit_cnt_n = bit_cnt_q;
      done_n    = 1'b0;
      if (state_q != IDLE && abort) begin
         state_n   = IDLE;
         bit_cnt_n = '0;
      end else begin
         case (state_q)
            IDLE: begin
               accept = in_ready && in_valid && !abort;
               if (accept) begin
                  state_n   = START;
                  mode      = MODE_LOAD;
                  bit_cnt_n = '0;
               end
            end
            START: begin
               if (bit_tick) state_n = DATA;
            end
            DATA: begin
               if (bit_tick) begin
                  mode = msb_q ? MODE_SHL : MODE_SHR;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_n   = STOP;
                     bit_cnt_n = '0;
                  end else begin
                     bit_cnt_n = bit_cnt_q + BIT_W'(1);
                  end
               end
            end
            STOP: begin
               if (bit_tick) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
               end
            end
         endcase
      end
   end

   // Datapath next values: shift register per mode, bit order latch, and the
   // line level that the next state will present.
   always_comb begin
      shreg_n = shreg_q;
      case (mode)
         MODE_LOAD: shreg_n = DATAIN;
         MODE_SHL:  shreg_n = {shreg_q[WIDTH-2:0], 1'b0};
         MODE_SHR:  shreg_n = {1'b0, shreg_q[WIDTH-1:1]};
         default:   shreg_n = shreg_q;
      endcase
      if (state_q != IDLE && abort) shreg_n = '0;
      msb_n = accept ? msb_first : msb_q;
      case (state_n)
         START:   serial_n = 1'b0;
         DATA:    serial_n = msb_n ? shreg_n[WIDTH-1] : shreg_n[0];
         default: serial_n = 1'b1;
      endcase
   end

   // State and datapath registers; the line output is registered so reset
   // drives it straight to idle-high without a combinational glitch.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         msb_q      <= 1'b0;
         armed_q    <= 1'b0;
         serial_out <= 1'b1;
         done       <= 1'b0;
      end else begin
         state_q    <= state_n;
         shreg_q    <= shreg_n;
         bit_cnt_q  <= bit_cnt_n;
         msb_q      <= msb_n;
         armed_q    <= 1'b1;
         serial_out <= serial_n;
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_usr_serializer.sv
// Bench for usr_serializer: two instances (DIV=1 and DIV=3, WIDTH=4) driven
// by directed and random frames, checked cycle by cycle against a waveform
// built from the frame rules (start, ordered data bits, stop, done pulse).
module tb_usr_serializer;

   localparam int W = 4;

   logic       clock;
   logic       rst   [2];
   logic       iv    [2];
   logic       ir    [2];
   logic [3:0] din   [2];
   logic       mf    [2];
   logic       ab    [2];
   logic       so    [2];
   logic       bz    [2];
   logic       dn    [2];

   int tests_run;
   int tests_failed;

   usr_serializer #(.WIDTH(4), .DIV(1)) u_div1 (
      .clock(clock), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .DATAIN(din[0]), .msb_first(mf[0]), .abort(ab[0]),
      .serial_out(so[0]), .busy(bz[0]), .done(dn[0])
   );

   usr_serializer #(.WIDTH(4), .DIV(3)) u_div3 (
      .clock(clock), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .DATAIN(din[1]), .msb_first(mf[1]), .abort(ab[1]),
      .serial_out(so[1]), .busy(bz[1]), .done(dn[1])
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic checkOutput(input string tag, input logic obs, input logic exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input int d, input string tag, input logic rdy);
      checkOutput($sformatf("d%0d %s serial", d, tag), so[d], 1'b1);
      checkOutput($sformatf("d%0d %s busy", d, tag), bz[d], 1'b0);
      checkOutput($sformatf("d%0d %s done", d, tag), dn[d], 1'b0);
      checkOutput($sformatf("d%0d %s in_ready", d, tag), ir[d], rdy);
   endtask

   task automatic applyStimulus(input int d, input logic [3:0] w, input logic m);
      checkOutput($sformatf("d%0d ready before send", d), ir[d], 1'b1);
      iv[d]  = 1'b1;
      din[d] = w;
      mf[d]  = m;
   endtask

   task automatic idleCycles(input int d, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         checkIdle(d, "idle", 1'b1);
      end
   endtask

   // Walks 'upto' cycles of the frame for word w, comparing against the
   // expected line waveform; a complete walk also checks the done cycle.
   task automatic walkFrame(input int d, input logic [3:0] w, input logic m,
                            input int upto, input bit hold,
                            input logic [3:0] nw, input logic nm);
      int   div;
      int   n;
      logic b;
      logic exp_q[$];
      div = (d == 0) ? 1 : 3;
      exp_q.delete();
      repeat (div) exp_q.push_back(1'b0);
      for (int i = 0; i < W; i++) begin
         b = m ? w[W-1-i] : w[i];
         repeat (div) exp_q.push_back(b);
      end
      repeat (div) exp_q.push_back(1'b1);
      n = (upto > exp_q.size()) ? exp_q.size() : upto;
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         checkOutput($sformatf("d%0d w%h c%0d serial", d, w, c), so[d], exp_q[c]);
         checkOutput($sformatf("d%0d w%h c%0d busy", d, w, c), bz[d], 1'b1);
         checkOutput($sformatf("d%0d w%h c%0d done", d, w, c), dn[d], 1'b0);
         checkOutput($sformatf("d%0d w%h c%0d in_ready", d, w, c), ir[d], 1'b0);
         if (c == n - 1) begin
            iv[d]  = hold;
            din[d] = nw;
            mf[d]  = nm;
         end else begin
            iv[d]  = hold ? 1'b1 : 1'($urandom_range(0, 1));
            din[d] = 4'($urandom);
            mf[d]  = 1'($urandom);
         end
      end
      if (n == exp_q.size()) begin
         @(negedge clock);
         checkOutput($sformatf("d%0d w%h done pulse", d, w), dn[d], 1'b1);
         checkOutput($sformatf("d%0d w%h done serial", d, w), so[d], 1'b1);
         checkOutput($sformatf("d%0d w%h done busy", d, w), bz[d], 1'b0);
         checkOutput($sformatf("d%0d w%h done in_ready", d, w), ir[d], 1'b1);
      end
   endtask

   // Directed and random sequence for both instances.
   initial begin
      logic [3:0] w;
      logic       m;
      int         div;
      tests_run    = 0;
      tests_failed = 0;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; iv[d] = 1'b0; din[d] = 4'h0; mf[d] = 1'b0; ab[d] = 1'b0;
      end

      @(negedge clock);
      for (int d = 0; d < 2; d++) checkIdle(d, "in reset", 1'b0);
      @(negedge clock);
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) checkIdle(d, "just released", 1'b0);
      @(negedge clock);
      for (int d = 0; d < 2; d++) checkIdle(d, "first edge", 1'b1);

      // LSB-first 0011 at DIV=1, then MSB-first 1010 at DIV=3.
      applyStimulus(0, 4'b0011, 1'b0);
      walkFrame(0, 4'b0011, 1'b0, 99, 1'b0, 4'h0, 1'b0);
      idleCycles(0, 1);
      applyStimulus(1, 4'b1010, 1'b1);
      walkFrame(1, 4'b1010, 1'b1, 99, 1'b0, 4'h0, 1'b0);
      idleCycles(1, 1);

      // Back-to-back words with in_valid held high.
      for (int d = 0; d < 2; d++) begin
         m = 1'(d);
         applyStimulus(d, 4'b0111, m);
         walkFrame(d, 4'b0111, m, 99, 1'b1, 4'b1000, m);
         walkFrame(d, 4'b1000, m, 99, 1'b0, 4'h0, 1'b0);
         idleCycles(d, 1);
      end

      // Random words and bit orders with random idle gaps.
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 6; k++) begin
            w = 4'($urandom);
            m = 1'($urandom);
            idleCycles(d, $urandom_range(0, 2));
            applyStimulus(d, w, m);
            walkFrame(d, w, m, 99, 1'b0, 4'h0, 1'b0);
         end
      end

      // Abort together with in_valid in IDLE must not start a frame.
      for (int d = 0; d < 2; d++) begin
         iv[d] = 1'b1; ab[d] = 1'b1; din[d] = 4'hF;
         @(negedge clock);
         checkIdle(d, "abort in idle", 1'b1);
         iv[d] = 1'b0; ab[d] = 1'b0;
         idleCycles(d, 1);
      end

      // Abort during data bit 2, then a normal frame to show recovery.
      for (int d = 0; d < 2; d++) begin
         div = (d == 0) ? 1 : 3;
         w = 4'($urandom);
         m = 1'($urandom);
         applyStimulus(d, w, m);
         walkFrame(d, w, m, div * 3 + 1, 1'b0, 4'h0, 1'b0);
         ab[d] = 1'b1;
         @(negedge clock);
         checkIdle(d, "after abort", 1'b1);
         ab[d] = 1'b0;
         @(negedge clock);
         checkIdle(d, "after abort +1", 1'b1);
         w = 4'($urandom);
         applyStimulus(d, w, m);
         walkFrame(d, w, m, 99, 1'b0, 4'h0, 1'b0);
      end

      // Reset asserted mid-STOP acts without a clock edge; 1111 afterwards.
      for (int d = 0; d < 2; d++) begin
         div = (d == 0) ? 1 : 3;
         w = 4'($urandom);
         m = 1'($urandom);
         applyStimulus(d, w, m);
         walkFrame(d, w, m, div * (W + 1) + 1, 1'b0, 4'h0, 1'b0);
         #2;
         rst[d] = 1'b0;
         #1;
         checkIdle(d, "async reset", 1'b0);
         @(negedge clock);
         checkIdle(d, "held reset", 1'b0);
         rst[d] = 1'b1;
         @(negedge clock);
         checkIdle(d, "reset released", 1'b1);
         applyStimulus(d, 4'b1111, m);
         walkFrame(d, 4'b1111, m, 99, 1'b0, 4'h0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
